alu_seq: RTL and testbench

- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Adds XOR, signed/unsigned compare, shifts, and iterative multiply/divide/remainder, with registered outputs.
- Sits in the execute stage. The pipeline stalls on in_ready/out_valid while a multi-cycle op runs.
- Opcodes 0000–0011 keep their existing meanings.

---
 rtl/alu_seq.sv | 103 ++++++++++
 tb/tb_alu_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle ops and iterative multiply/divide/remainder.
// Operands are captured on accept; results are registered and held until taken.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_n;
    logic [SHW-1:0] cnt;
    logic [3:0] op;
    logic [WIDTH-1:0] acc, sh, md, alu_r, acc_n, sh_n, md_n, diff, fin;
    logic [WIDTH:0] t;
    logic accept, multi, last, ge, mul;
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign busy = state != IDLE;
    assign accept = in_valid && in_ready;
    assign multi = alu_ctrl inside {4'd10, 4'd11, 4'd12};
    assign last = cnt == SHW'(WIDTH - 1);
    always_comb begin
        alu_r = '0;
        case (alu_ctrl)
            4'd0: alu_r = a + b;
            4'd1: alu_r = a - b;
            4'd2: alu_r = a & b;
            4'd3: alu_r = a | b;
            4'd4: alu_r = a ^ b;
            4'd5: alu_r = WIDTH'($signed(a) < $signed(b));
            4'd6: alu_r = WIDTH'(a < b);
            4'd7: alu_r = a << b[SHW-1:0];
            4'd8: alu_r = a >> b[SHW-1:0];
            4'd9: alu_r = $signed(a) >>> b[SHW-1:0];
            default: alu_r = '0;
        endcase
    end
    // acc: partial product or remainder; sh: multiplier or dividend/quotient; md: multiplicand or divisor
    always_comb begin
        mul = op == 4'd10;
        t = {acc, sh[WIDTH-1]};
        diff = t[WIDTH-1:0] - md;
        ge = t >= {1'b0, md};
        acc_n = mul ? acc + (sh[0] ? md : '0) : ge ? diff : t[WIDTH-1:0];
        sh_n = mul ? sh >> 1 : {sh[WIDTH-2:0], ge};
        md_n = mul ? md << 1 : md;
        fin = op == 4'd11 ? sh_n : acc_n;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = multi ? CALC : DONE;
            CALC: if (last) state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            op <= '0;
            acc <= '0;
            sh <= '0;
            md <= '0;
            result <= '0;
            zero <= 1'b0;
        end else if (accept) begin
            op <= alu_ctrl;
            cnt <= '0;
            acc <= '0;
            sh <= alu_ctrl == 4'd10 ? b : a;
            md <= alu_ctrl == 4'd10 ? a : b;
            if (!multi) begin
                result <= alu_r;
                zero <= alu_r == '0;
            end
        end else if (state == CALC) begin
            acc <= acc_n;
            sh <= sh_n;
            md <= md_n;
            cnt <= cnt + 1'b1;
            if (last) begin
                result <= fin;
                zero <= fin == '0;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
    logic clk = 0, rst = 1;
    logic in_valid = 0, out_ready = 0, in_ready, out_valid, zero, busy;
    logic [31:0] a = 0, b = 0, result;
    logic [3:0] alu_ctrl = 0;
    logic iv8 = 0, or8 = 0, ir8, ov8, z8, bz8;
    logic [7:0] a8 = 0, b8 = 0, r8;
    logic [3:0] c8 = 0;
    int total = 0, bad = 0;
    bit chk_on = 0;
    logic m_rdy, m_vld;
    logic [31:0] m_res, m_pend;
    int m_left;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_ctrl(alu_ctrl), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy));

    alu_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .alu_ctrl(c8), .out_valid(ov8), .out_ready(or8),
        .result(r8), .zero(z8), .busy(bz8));

    function automatic logic [31:0] ref32(input logic [31:0] x, y, input logic [3:0] op);
        case (op)
            4'd0: return x + y;
            4'd1: return x - y;
            4'd2: return x & y;
            4'd3: return x | y;
            4'd4: return x ^ y;
            4'd5: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd6: return (x < y) ? 32'd1 : 32'd0;
            4'd7: return x << y[4:0];
            4'd8: return x >> y[4:0];
            4'd9: return $signed(x) >>> y[4:0];
            4'd10: return x * y;
            4'd11: return y == 0 ? 32'hFFFF_FFFF : x / y;
            4'd12: return y == 0 ? x : x % y;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // transaction-level model: accept, count down the iterative latency, hold until taken
    always @(posedge clk) begin
        if (rst) begin
            m_rdy <= 1;
            m_vld <= 0;
            m_left <= 0;
            m_res <= 0;
        end else if (m_rdy && in_valid) begin
            m_rdy <= 0;
            if (alu_ctrl inside {4'd10, 4'd11, 4'd12}) begin
                m_left <= 32;
                m_pend <= ref32(a, b, alu_ctrl);
            end else begin
                m_vld <= 1;
                m_res <= ref32(a, b, alu_ctrl);
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_vld <= 1;
                m_res <= m_pend;
            end
        end else if (m_vld && out_ready) begin
            m_vld <= 0;
            m_rdy <= 1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("in_ready", 32'(in_ready), 32'(m_rdy));
            chk("out_valid", 32'(out_valid), 32'(m_vld));
            chk("busy", 32'(busy), 32'(!m_rdy));
            if (m_vld) begin
                chk("result", result, m_res);
                chk("zero", 32'(zero), 32'(m_res == 0));
            end
        end
    end

    task automatic run(input logic [31:0] ta, tv, input logic [3:0] op, input logic [31:0] exp,
                       input int lat, input int hold);
        int n;
        a = ta; b = tv; alu_ctrl = op; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0; a = $urandom; b = $urandom; alu_ctrl = 4'($urandom);
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(lat));
        chk("d_result", result, exp);
        chk("d_zero", 32'(zero), 32'(exp == 0));
        repeat (hold) begin
            in_valid = 1'($urandom);
            @(posedge clk); #1;
            chk("hold_result", result, exp);
            chk("hold_zero", 32'(zero), 32'(exp == 0));
            chk("hold_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("taken_valid", 32'(out_valid), 32'd0);
        chk("taken_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic run8(input logic [7:0] ta, tv, input logic [3:0] op, input logic [7:0] exp, input int lat);
        int n;
        a8 = ta; b8 = tv; c8 = op; iv8 = 1;
        @(posedge clk); #1;
        iv8 = 0;
        n = 1;
        while (!ov8 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w8_latency", 32'(n), 32'(lat));
        chk("w8_result", 32'(r8), 32'(exp));
        or8 = 1;
        @(posedge clk); #1;
        or8 = 0;
        chk("w8_taken", 32'(ov8), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk_on = 1;
        run(32'd5, 32'd7, 4'd0, 32'd12, 1, 0);
        run(32'd9, 32'd9, 4'd1, 32'd0, 1, 0);
        run(32'hFFFF_FFFF, 32'd1, 4'd5, 32'd1, 1, 0);
        run(32'hFFFF_FFFF, 32'd1, 4'd6, 32'd0, 1, 0);
        run(32'h8000_0000, 32'h21, 4'd9, 32'hC000_0000, 1, 0);
        run(32'h0000_1234, 32'h24, 4'd7, 32'h0001_2340, 1, 0);
        run(32'hF0F0_0000, 32'h0FF0_0000, 4'd4, 32'hFF00_0000, 1, 0);
        run(32'd77, 32'd3, 4'd14, 32'd0, 1, 0);
        run(32'h0001_0000, 32'h0001_0003, 4'd10, 32'h0003_0000, 33, 0);
        run(32'd100, 32'd7, 4'd11, 32'd14, 33, 0);
        run(32'd100, 32'd7, 4'd12, 32'd2, 33, 0);
        run(32'd100, 32'd0, 4'd11, 32'hFFFF_FFFF, 33, 0);
        run(32'd123, 32'd0, 4'd12, 32'd123, 33, 0);
        run(32'h0000_00F0, 32'h0000_000F, 4'd3, 32'h0000_00FF, 1, 10);
        run(32'd6, 32'd7, 4'd10, 32'd42, 33, 10);
        a = 32'd1000; b = 32'd9; alu_ctrl = 4'd11; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (5) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        run8(8'd15, 8'd17, 4'd10, 8'hFF, 9);
        run8(8'd200, 8'd7, 4'd11, 8'd28, 9);
        run8(8'd200, 8'd7, 4'd12, 8'd4, 9);
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom % 600) == 0;
            in_valid = ($urandom % 3) != 0;
            alu_ctrl = 4'($urandom);
            a = ($urandom % 8 == 0) ? $urandom % 256 : $urandom;
            b = ($urandom % 4 == 0) ? $urandom % 16 : $urandom;
            out_ready = 1'($urandom);
            @(posedge clk); #1;
        end
        rst = 0; in_valid = 0; out_ready = 0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
